// File: rtl/fwuart_pkg.sv
// Shared types and constants for the fwuart receiver: state encoding,
// oversampling geometry and the 2-of-3 vote helper.
package fwuart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int VOTE_LO    = 7;
    localparam int VOTE_MID   = 8;
    localparam int VOTE_HI    = 9;
    localparam int DATA_BITS  = 8;

    // Width-matched forms for direct comparison against the counters.
    localparam logic [3:0] VOTE_LO_CNT  = 4'(VOTE_LO);
    localparam logic [3:0] VOTE_MID_CNT = 4'(VOTE_MID);
    localparam logic [3:0] VOTE_HI_CNT  = 4'(VOTE_HI);
    localparam logic [3:0] TICK_LAST    = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] BIT_LAST     = 3'(DATA_BITS - 1);

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/fwuart_sync.sv
// Multi-flop synchroniser for the asynchronous rx line; resets to the idle
// (high) level so no false start edge appears when reset is released.
module fwuart_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) chain <= '1;
        else       chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/fwuart_rx.sv
// 8N1 UART receiver, 16x oversampled with a 3-sample mid-bit vote; delivers
// bytes on a valid/ready port and pulses framing_error / overrun.
module fwuart_rx
    import fwuart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clock_x16,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       framing_error,
    output logic       overrun,
    output logic       busy
);

    rx_state_t  state, state_next;
    logic       rx_s, rx_prev;
    logic       sample_lo, sample_mid, vote;
    logic       tick_vote, tick_end;
    logic       byte_done, frame_bad;
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift;

    fwuart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign vote      = majority3(sample_lo, sample_mid, rx_s);
    assign tick_vote = clock_x16 && (tick_cnt == VOTE_HI_CNT);
    assign tick_end  = clock_x16 && (tick_cnt == TICK_LAST);
    assign busy      = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output is defaulted first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        byte_done  = 1'b0;
        frame_bad  = 1'b0;
        unique case (state)
            IDLE: begin
                if (clock_x16 && !rx_s && rx_prev) state_next = START;
            end
            START: begin
                if (tick_vote && vote) state_next = IDLE;
                else if (tick_end)     state_next = DATA;
            end
            DATA: begin
                if (tick_end && bit_cnt == BIT_LAST) state_next = STOP;
            end
            STOP: begin
                // Leave at mid-stop so a back-to-back sender's next start edge is seen.
                if (tick_vote) begin
                    state_next = IDLE;
                    byte_done  = vote;
                    frame_bad  = !vote;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_prev    <= 1'b1;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            sample_lo  <= 1'b1;
            sample_mid <= 1'b1;
        end else if (clock_x16) begin
            rx_prev  <= rx_s;
            tick_cnt <= (state == IDLE) ? 4'd0 : tick_cnt + 4'd1;
            if (tick_cnt == VOTE_LO_CNT)  sample_lo  <= rx_s;
            if (tick_cnt == VOTE_MID_CNT) sample_mid <= rx_s;
            if (state == START && tick_end) bit_cnt <= '0;
            if (state == DATA) begin
                if (tick_vote) shift   <= {vote, shift[7:1]};
                if (tick_end)  bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data          <= 8'h00;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= frame_bad;
            overrun       <= 1'b0;
            if (byte_done) begin
                if (!data_valid || data_ready) begin
                    data       <= shift;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule
